// File: rtl/softmax_pkg.sv
// Shared softmax datapath constants: value width, default vector geometry,
// collector/replay state encoding and the Q0.32 encoding of e^0.
package softmax_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int VECTOR_LEN = 8;
    localparam int ADDR_SIZE  = 3;

    // Q0.32 unsigned value used for e^0 (largest representable exp value)
    localparam logic [DATA_SIZE-1:0] EXP_ONE = 32'hFFFF_FFFF;

    // Collector sequencing: gather a vector, replay it, then one idle cycle
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REPLAY  = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/exp_sum_buffer_if.sv
// Handshake bundle between the exp LUT, the sum buffer and the divider.
// master: the surrounding datapath (drives exp values, accepts replays).
// slave:  the exp_sum_buffer block.
interface exp_sum_buffer_if
    import softmax_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int addr_size = ADDR_SIZE
);
    // upstream side
    logic                           exp_valid_i;
    logic [data_size-1:0]           exp_data_i;
    logic                           ready_o;
    // downstream side
    logic [data_size+addr_size-1:0] sum_o;
    logic                           sum_valid_o;
    logic [data_size-1:0]           data_o;
    logic                           data_valid_o;
    logic                           data_ready_i;
    logic                           last_o;
    logic                           done_o;

    modport master (
        output exp_valid_i, exp_data_i, data_ready_i,
        input  ready_o, sum_o, sum_valid_o, data_o, data_valid_o, last_o, done_o
    );

    modport slave (
        input  exp_valid_i, exp_data_i, data_ready_i,
        output ready_o, sum_o, sum_valid_o, data_o, data_valid_o, last_o, done_o
    );

endinterface

// File: rtl/exp_vec_buffer.sv
// Vector storage for one softmax vector: one synchronous write port and a
// combinational read port. Storage is not reset; contents are only
// meaningful after they have been written during collection.
module exp_vec_buffer
    import softmax_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int vector_len = VECTOR_LEN,
    parameter int addr_size  = ADDR_SIZE
) (
    input  logic                 clock_i,
    input  logic                 we,
    input  logic [addr_size-1:0] waddr,
    input  logic [data_size-1:0] wdata,
    input  logic [addr_size-1:0] raddr,
    output logic [data_size-1:0] rdata
);

    logic [data_size-1:0] mem [vector_len];

    generate
        for (genvar gi = 0; gi < vector_len; gi++) begin : g_entry
            // Capture the incoming value into the addressed entry
            always_ff @(posedge clock_i) begin
                if (we && (waddr == addr_size'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem[raddr];

endmodule

// File: rtl/exp_sum_buffer.sv
// Softmax exp-sum stage: collects vector_len exp values while summing them,
// then replays each stored value together with the final sum to the divider.
// Replay data is prefetched into an output register so data_o never comes
// from a combinational read path.
module exp_sum_buffer
    import softmax_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int vector_len = VECTOR_LEN,
    parameter int addr_size  = ADDR_SIZE
) (
    input  logic             clock_i,
    input  logic             reset_i,
    exp_sum_buffer_if.slave  bus
);

    localparam int                   SUM_SIZE = data_size + addr_size;
    localparam logic [addr_size-1:0] LAST_IDX = addr_size'(vector_len - 1);

    state_t                 state_reg;
    logic [addr_size-1:0]   wr_cnt_reg;
    logic [addr_size-1:0]   rd_cnt_reg;
    logic [SUM_SIZE-1:0]    sum_reg;
    logic [SUM_SIZE-1:0]    sum_next;
    logic [data_size-1:0]   data_reg;
    logic                   ready_reg;
    logic                   data_valid_reg;
    logic                   sum_valid_reg;
    logic                   last_reg;
    logic                   done_reg;

    logic                   buf_we;
    logic [addr_size-1:0]   buf_raddr;
    logic [addr_size-1:0]   rd_cnt_next;
    logic [data_size-1:0]   buf_rdata;
    logic                   accept;
    logic                   transfer;

    assign accept      = (state_reg == COLLECT) && bus.exp_valid_i;
    assign transfer    = data_valid_reg && bus.data_ready_i;
    assign buf_we      = accept;
    assign sum_next    = sum_reg + {{addr_size{1'b0}}, bus.exp_data_i};
    assign rd_cnt_next = rd_cnt_reg + addr_size'(1);
    // During collection element 0 is prefetched for the first replay beat;
    // during replay the element after the current one is prefetched.
    assign buf_raddr   = (state_reg == REPLAY) ? rd_cnt_next : '0;

    exp_vec_buffer #(
        .data_size  (data_size),
        .vector_len (vector_len),
        .addr_size  (addr_size)
    ) u_vec_buffer (
        .clock_i (clock_i),
        .we      (buf_we),
        .waddr   (wr_cnt_reg),
        .wdata   (bus.exp_data_i),
        .raddr   (buf_raddr),
        .rdata   (buf_rdata)
    );

    // Sequencer: counters, accumulator and registered handshake outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= COLLECT;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            sum_reg        <= '0;
            data_reg       <= '0;
            ready_reg      <= 1'b1;
            data_valid_reg <= 1'b0;
            sum_valid_reg  <= 1'b0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        sum_reg <= sum_next;
                        if (wr_cnt_reg == LAST_IDX) begin
                            wr_cnt_reg     <= '0;
                            state_reg      <= REPLAY;
                            ready_reg      <= 1'b0;
                            data_valid_reg <= 1'b1;
                            sum_valid_reg  <= 1'b1;
                            data_reg       <= buf_rdata;
                            last_reg       <= 1'b0;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + addr_size'(1);
                        end
                    end
                end
                REPLAY: begin
                    if (transfer) begin
                        if (last_reg) begin
                            rd_cnt_reg     <= '0;
                            state_reg      <= DONE;
                            data_valid_reg <= 1'b0;
                            sum_valid_reg  <= 1'b0;
                            last_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                            data_reg       <= '0;
                        end else begin
                            rd_cnt_reg <= rd_cnt_next;
                            data_reg   <= buf_rdata;
                            last_reg   <= (rd_cnt_next == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    sum_reg   <= '0;
                    ready_reg <= 1'b1;
                    state_reg <= COLLECT;
                end
                default: begin
                    state_reg      <= COLLECT;
                    wr_cnt_reg     <= '0;
                    rd_cnt_reg     <= '0;
                    sum_reg        <= '0;
                    data_reg       <= '0;
                    ready_reg      <= 1'b1;
                    data_valid_reg <= 1'b0;
                    sum_valid_reg  <= 1'b0;
                    last_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o      = ready_reg;
    assign bus.sum_o        = sum_reg;
    assign bus.sum_valid_o  = sum_valid_reg;
    assign bus.data_o       = data_reg;
    assign bus.data_valid_o = data_valid_reg;
    assign bus.last_o       = last_reg;
    assign bus.done_o       = done_reg;

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Directed bench for exp_sum_buffer: a table of vectors driven back to back
// (collect + replay each), followed by hand-written reset sequences.
module tb_exp_sum_buffer;
    import softmax_pkg::*;

    logic clk;
    logic rst;

    exp_sum_buffer_if #(.data_size(32), .addr_size(3)) bus ();

    exp_sum_buffer #(
        .data_size  (32),
        .vector_len (8),
        .addr_size  (3)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][31:0] din;
        bit               stall;
        bit               junk;
        logic [34:0]      sum;
    } vec_t;

    vec_t tbl [7];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present eight values on consecutive collect cycles; returns at the
    // falling edge just after the eighth accept.
    task automatic feed(input logic [7:0][31:0] din);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("collect_ready", bus.ready_o, 1);
            check("collect_valid", bus.data_valid_o, 0);
            check("collect_sum_valid", bus.sum_valid_o, 0);
            check("collect_done", bus.done_o, 0);
            if (i == 0) check("collect_sum_start", bus.sum_o, 0);
            bus.exp_valid_i = 1'b1;
            bus.exp_data_i  = din[i];
        end
        @(negedge clk);
        bus.exp_valid_i = 1'b0;
        bus.exp_data_i  = '0;
    endtask

    // Consume n_xfer replay beats, checking every presented beat.
    task automatic replay(input logic [7:0][31:0] din, input bit stall, input bit junk,
                          input logic [34:0] esum, input int n_xfer);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        bus.exp_valid_i = junk;
        bus.exp_data_i  = junk ? 32'hDEAD_BEEF : 32'h0;
        while (idx < n_xfer && cyc < 40) begin
            check("replay_valid", bus.data_valid_o, 1);
            check("replay_sum_valid", bus.sum_valid_o, 1);
            check("replay_sum", bus.sum_o, esum);
            check("replay_data", bus.data_o, din[idx]);
            check("replay_last", bus.last_o, (idx == 7) ? 1 : 0);
            check("replay_ready", bus.ready_o, 0);
            rdy = stall ? (cyc % 2 == 1) : 1'b1;
            bus.data_ready_i = rdy;
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.data_ready_i = 1'b0;
        check("xfer_count", idx, n_xfer);
        if (n_xfer == 8) begin
            check("done_pulse", bus.done_o, 1);
            check("done_valid", bus.data_valid_o, 0);
            check("done_sum_valid", bus.sum_valid_o, 0);
            check("done_ready", bus.ready_o, 0);
            check("done_last", bus.last_o, 0);
        end
    endtask

    initial begin
        logic [7:0][31:0] v;

        for (int i = 0; i < 8; i++) begin
            tbl[0].din[i] = EXP_ONE;
            tbl[1].din[i] = 32'(i + 1);
            tbl[2].din[i] = 32'(i + 10);
            tbl[3].din[i] = 32'h0;
            tbl[4].din[i] = 32'd5;
            tbl[5].din[i] = 32'd3;
            tbl[6].din[i] = 32'(8 - i);
        end
        tbl[0].stall = 0; tbl[0].junk = 0; tbl[0].sum = 35'h7_FFFF_FFF8;
        tbl[1].stall = 0; tbl[1].junk = 0; tbl[1].sum = 35'd36;
        tbl[2].stall = 1; tbl[2].junk = 0; tbl[2].sum = 35'd108;
        tbl[3].stall = 0; tbl[3].junk = 1; tbl[3].sum = 35'd0;
        tbl[4].stall = 0; tbl[4].junk = 0; tbl[4].sum = 35'd40;
        tbl[5].stall = 0; tbl[5].junk = 0; tbl[5].sum = 35'd24;
        tbl[6].stall = 0; tbl[6].junk = 0; tbl[6].sum = 35'd36;

        bus.exp_valid_i  = 1'b0;
        bus.exp_data_i   = '0;
        bus.data_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_sum_valid", bus.sum_valid_o, 0);
        check("rst_data_valid", bus.data_valid_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_sum", bus.sum_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_ready", bus.ready_o, 1);

        // Table: vectors run back to back, each starting in the first
        // collect cycle after the previous done pulse.
        for (int t = 0; t < 7; t++) begin
            feed(tbl[t].din);
            replay(tbl[t].din, tbl[t].stall, tbl[t].junk, tbl[t].sum, 8);
            $display("vector %0d replayed, expected sum %0h, observed sum seen during replay", t, tbl[t].sum);
        end
        bus.exp_valid_i = 1'b0;

        // Reset in the middle of collection discards the partial sum
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.exp_valid_i = 1'b1;
            bus.exp_data_i  = EXP_ONE;
        end
        @(negedge clk);
        bus.exp_valid_i = 1'b0;
        check("partial_sum_before_rst", bus.sum_o, 35'h2_FFFF_FFFD);
        rst = 1'b1;
        #1;
        check("collect_rst_sum", bus.sum_o, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset during collect applied");

        // Reset between clock edges after the third replay transfer
        for (int i = 0; i < 8; i++) v[i] = 32'd9;
        feed(v);
        replay(v, 0, 0, 35'd72, 3);
        check("pre_rst_valid", bus.data_valid_o, 1);
        check("pre_rst_data", bus.data_o, 32'd9);
        rst = 1'b1;
        #1;
        check("async_rst_data_valid", bus.data_valid_o, 0);
        check("async_rst_sum_valid", bus.sum_valid_o, 0);
        check("async_rst_last", bus.last_o, 0);
        check("async_rst_sum", bus.sum_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.ready_o, 1);
        $display("reset during replay applied");

        for (int i = 0; i < 8; i++) v[i] = 32'd2;
        feed(v);
        replay(v, 0, 0, 35'd16, 8);
        $display("post-reset vector replayed, expected sum 10");

        @(negedge clk);
        check("final_ready", bus.ready_o, 1);
        check("final_done_low", bus.done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
